// File: rtl/clk_div_prog_pkg.sv
// clk_div_prog_pkg - shared constants and edge classification for the
// programmable clock divider. Pulls in the board constants from clk_div_defs.vh.
package clk_div_prog_pkg;

`include "clk_div_defs.vh"

  // What a channel's divided clock does on the coming clk edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // A toggle only happens while the channel runs and its counter wraps;
  // the current output level decides whether it is a rise or a fall.
  function automatic edge_e classify_edge(input logic run,
                                          input logic wrap,
                                          input logic level);
    edge_e kind;
    kind = EDGE_NONE;
    if (run && wrap) begin
      kind = level ? EDGE_FALL : EDGE_RISE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch - one divider channel: half-period counter, active/shadow ratio
// registers with a pending flag, 50%-duty output and rise tick.
// Optional macro CLK_DIV_FALL_TICK_EN adds a tick_fall output on 1->0 toggles.
module clk_div_ch
  import clk_div_prog_pkg::*;
#(
  parameter int               CNT_W     = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] INIT_HALF = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
`ifdef CLK_DIV_FALL_TICK_EN
  ,
  output logic             tick_fall
`endif
);

  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic [CNT_W-1:0] act_half_reg, act_half_next;
  logic [CNT_W-1:0] shadow_reg,   shadow_next;
  logic             pend_reg,     pend_next;
  logic             clk_out_reg,  clk_out_next;
  logic             tick_reg,     tick_next;
`ifdef CLK_DIV_FALL_TICK_EN
  logic             tick_fall_reg, tick_fall_next;
`endif

  logic [CNT_W-1:0] eff_half;
  logic             run;
  logic             wrap;
  logic             load;
  edge_e            edge_kind;

  // Effective half-period (H=0 behaves as H=1) and wrap/edge decode.
  // The >= compare also recovers if cnt is ever above the terminal value.
  always_comb begin
    eff_half  = (act_half_reg == '0) ? CNT_W'(1) : act_half_reg;
    run       = en && !sync;
    wrap      = (cnt_reg >= (eff_half - CNT_W'(1)));
    edge_kind = classify_edge(run, wrap, clk_out_reg);
  end

  // Ratio reload: only at a full-period end, or at once while held idle,
  // so a running output never sees a partial period.
  always_comb begin
    load          = pend_reg && (!run || (edge_kind == EDGE_FALL));
    act_half_next = load ? shadow_reg : act_half_reg;
    shadow_next   = wr ? wr_half : shadow_reg;
    // A write in the same cycle as a load keeps the new value pending.
    pend_next     = wr || (pend_reg && !load);
  end

  // Counter and output toggle; idle or sync parks everything at phase 0.
  always_comb begin
    cnt_next     = '0;
    clk_out_next = 1'b0;
    tick_next    = 1'b0;
    if (run) begin
      cnt_next     = wrap ? '0 : (cnt_reg + CNT_W'(1));
      clk_out_next = (edge_kind == EDGE_NONE) ? clk_out_reg : !clk_out_reg;
      tick_next    = (edge_kind == EDGE_RISE);
    end
  end

`ifdef CLK_DIV_FALL_TICK_EN
  // Falling-toggle pulse, gated exactly like the rise tick.
  always_comb begin
    tick_fall_next = (edge_kind == EDGE_FALL);
  end
`endif

  // Channel state register; reset restores the build-time ratio.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      act_half_reg <= INIT_HALF;
      shadow_reg   <= INIT_HALF;
      pend_reg     <= 1'b0;
      clk_out_reg  <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      act_half_reg <= act_half_next;
      shadow_reg   <= shadow_next;
      pend_reg     <= pend_next;
      clk_out_reg  <= clk_out_next;
      tick_reg     <= tick_next;
    end
  end

`ifdef CLK_DIV_FALL_TICK_EN
  // Falling-tick register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_fall_reg <= 1'b0;
    end else begin
      tick_fall_reg <= tick_fall_next;
    end
  end

  assign tick_fall = tick_fall_reg;
`endif

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign pend    = pend_reg;

endmodule

// File: rtl/clk_div_defs.vh
// clk_div_defs.vh - board-level constants shared by the clk_div_prog slice.
// Included inside clk_div_prog_pkg so every user sees them through the package.
`ifndef CLK_DIV_DEFS_VH
`define CLK_DIV_DEFS_VH

  // Board oscillator frequency in Hz.
  localparam int F_CLK = 100000000;

  // Half-periods (input-clock cycles) for the standard board rates.
  // f_out = F_CLK / (2 * H).
  localparam int HALF_2HZ   = 25000000;  // LED flash
  localparam int HALF_1KHZ  = 50000;     // display scan
  localparam int HALF_100HZ = 500000;    // button debounce sampling

  // Default half-period counter width; wide enough for HALF_2HZ.
  localparam int CNT_W_DEFAULT = 26;

`endif

// File: rtl/clk_div_prog.sv
// clk_div_prog - multi-channel runtime-programmable clock divider / tick
// generator. Each channel gives a 50%-duty clock of f_clk/(2*H) plus a
// one-cycle tick on every rising toggle; new ratios load at period ends.
// Optional macro CLK_DIV_FALL_TICK_EN adds tick_fall[NUM_CH].
// Requires 1 <= NUM_CH <= 16 and 2**CH_W >= NUM_CH.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int                      NUM_CH    = 3,
  parameter int                      CNT_W     = CNT_W_DEFAULT,
  parameter int                      CH_W      = 2,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_HALF = {CNT_W'(HALF_100HZ),
                                                  CNT_W'(HALF_1KHZ),
                                                  CNT_W'(HALF_2HZ)}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend
`ifdef CLK_DIV_FALL_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick_fall
`endif
);

  // One channel per slot; writes to channel numbers >= NUM_CH match no slot
  // and are therefore dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr;

    assign wr = cfg_we && (int'(cfg_ch) == gi);

    clk_div_ch #(
      .CNT_W     (CNT_W),
      .INIT_HALF (INIT_HALF[gi*CNT_W +: CNT_W])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (ch_en[gi]),
      .sync      (sync),
      .wr        (wr),
      .wr_half   (cfg_half),
      .clk_out   (clk_out[gi]),
      .tick      (tick[gi]),
      .pend      (cfg_pend[gi])
`ifdef CLK_DIV_FALL_TICK_EN
      ,
      .tick_fall (tick_fall[gi])
`endif
    );
  end

endmodule
